// File: rtl/digi_clock_pkg.sv
// Shared types and limits for the clock time-setting path.
package digi_clock_pkg;

  typedef enum logic [2:0] {IDLE, SET_H, SET_M, SET_S, COMMIT} state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HOUR = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_SEC  = 2'd3;

  localparam int unsigned HOUR_MAX   = 23;
  localparam int unsigned MINSEC_MAX = 59;

  // Six BCD preset digits as driven to the clock counter
  typedef struct packed {
    logic [2:0] hd1;
    logic [3:0] hd0;
    logic [2:0] md1;
    logic [3:0] md0;
    logic [2:0] sd1;
    logic [3:0] sd0;
  } preset_t;

  function automatic logic bcd_in_range(input logic [2:0] tens, input logic [3:0] ones,
                                        input int unsigned max_val);
    return (ones <= 4'd9) && ((32'(tens) * 32'd10 + 32'(ones)) <= max_val);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-FF sync -> stability debounce -> one-cycle press pulse.
module key_debounce #(
  parameter int unsigned DEB_N = 1_000_000,
  parameter int unsigned DEB_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [DEB_W-1:0] cnt;

  // Counter runs only while the synced level disagrees with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DEB_W'(DEB_N - 1)) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= ~sync2;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Pushbutton time-setting front end: debounced keys, hour/min/sec edit FSM, level load.
// Optional blink of the edited field is enabled by defining TIME_SET_BLINK_EN.
module time_set_ctrl
  import digi_clock_pkg::*;
#(
  parameter int unsigned DEB_N  = 1_000_000,
  parameter int unsigned DEB_W  = 20,
  parameter int unsigned HOLD_N = 50_000_000,
  parameter int unsigned HOLD_W = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_key_mode,
  input  logic       i_key_up,
  input  logic       i_key_dn,
  input  logic [2:0] i_hq1,
  input  logic [3:0] i_hq0,
  input  logic [2:0] i_mq1,
  input  logic [3:0] i_mq0,
  input  logic [2:0] i_sq1,
  input  logic [3:0] i_sq0,
  output logic       o_load,
  output logic [2:0] o_hd1,
  output logic [3:0] o_hd0,
  output logic [2:0] o_md1,
  output logic [3:0] o_md0,
  output logic [2:0] o_sd1,
  output logic [3:0] o_sd0,
  output logic [1:0] o_sel,
  output logic       o_blank
);

  logic              press_mode;
  logic              press_up;
  logic              press_dn;
  logic              adj_up;
  logic              adj_dn;
  state_t            state;
  preset_t           edit;
  logic [HOLD_W-1:0] hold_cnt;

  key_debounce #(.DEB_N(DEB_N), .DEB_W(DEB_W)) u_deb_mode (
    .clk(clk), .rst_n(rst_n), .key(i_key_mode), .press(press_mode));
  key_debounce #(.DEB_N(DEB_N), .DEB_W(DEB_W)) u_deb_up (
    .clk(clk), .rst_n(rst_n), .key(i_key_up), .press(press_up));
  key_debounce #(.DEB_N(DEB_N), .DEB_W(DEB_W)) u_deb_dn (
    .clk(clk), .rst_n(rst_n), .key(i_key_dn), .press(press_dn));

  // Opposing presses in the same cycle cancel
  assign adj_up = press_up & ~press_dn;
  assign adj_dn = press_dn & ~press_up;

  // {tens, ones} BCD step with wrap at max_val
  function automatic logic [6:0] bcd_inc(input logic [6:0] v, input int unsigned max_val);
    if (v[6:4] == 3'(max_val / 10) && v[3:0] == 4'(max_val % 10)) return 7'd0;
    if (v[3:0] == 4'd9) return {v[6:4] + 3'd1, 4'd0};
    return {v[6:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_dec(input logic [6:0] v, input int unsigned max_val);
    if (v == 7'd0) return {3'(max_val / 10), 4'(max_val % 10)};
    if (v[3:0] == 4'd0) return {v[6:4] - 3'd1, 4'd9};
    return {v[6:4], v[3:0] - 4'd1};
  endfunction

  // Live time seeds the edit registers; out-of-range fields start at 00
  function automatic preset_t seed(input logic [2:0] h1, input logic [3:0] h0,
                                   input logic [2:0] m1, input logic [3:0] m0,
                                   input logic [2:0] s1, input logic [3:0] s0);
    preset_t p;
    p = '0;
    if (bcd_in_range(h1, h0, HOUR_MAX))   {p.hd1, p.hd0} = {h1, h0};
    if (bcd_in_range(m1, m0, MINSEC_MAX)) {p.md1, p.md0} = {m1, m0};
    if (bcd_in_range(s1, s0, MINSEC_MAX)) {p.sd1, p.sd0} = {s1, s0};
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      edit     <= '0;
      hold_cnt <= '0;
      o_load   <= 1'b0;
      o_sel    <= SEL_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (press_mode) begin
            state  <= SET_H;
            edit   <= seed(i_hq1, i_hq0, i_mq1, i_mq0, i_sq1, i_sq0);
            o_load <= 1'b1;
            o_sel  <= SEL_HOUR;
          end
        end
        SET_H: begin
          if (press_mode) begin
            state <= SET_M;
            o_sel <= SEL_MIN;
          end else if (adj_up) begin
            {edit.hd1, edit.hd0} <= bcd_inc({edit.hd1, edit.hd0}, HOUR_MAX);
          end else if (adj_dn) begin
            {edit.hd1, edit.hd0} <= bcd_dec({edit.hd1, edit.hd0}, HOUR_MAX);
          end
        end
        SET_M: begin
          if (press_mode) begin
            state <= SET_S;
            o_sel <= SEL_SEC;
          end else if (adj_up) begin
            {edit.md1, edit.md0} <= bcd_inc({edit.md1, edit.md0}, MINSEC_MAX);
          end else if (adj_dn) begin
            {edit.md1, edit.md0} <= bcd_dec({edit.md1, edit.md0}, MINSEC_MAX);
          end
        end
        SET_S: begin
          if (press_mode) begin
            state    <= COMMIT;
            o_sel    <= SEL_NONE;
            hold_cnt <= '0;
          end else if (adj_up) begin
            {edit.sd1, edit.sd0} <= bcd_inc({edit.sd1, edit.sd0}, MINSEC_MAX);
          end else if (adj_dn) begin
            {edit.sd1, edit.sd0} <= bcd_dec({edit.sd1, edit.sd0}, MINSEC_MAX);
          end
        end
        COMMIT: begin
          // Keep load asserted long enough for the divided clock to see it
          if (hold_cnt == HOLD_W'(HOLD_N - 1)) begin
            state  <= IDLE;
            o_load <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          o_load <= 1'b0;
          o_sel  <= SEL_NONE;
        end
      endcase
    end
  end

  assign o_hd1 = edit.hd1;
  assign o_hd0 = edit.hd0;
  assign o_md1 = edit.md1;
  assign o_md0 = edit.md0;
  assign o_sd1 = edit.sd1;
  assign o_sd0 = edit.sd0;

`ifdef TIME_SET_BLINK_EN
  logic [24:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      o_blank   <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt + 25'd1;
      o_blank   <= blink_cnt[24] & (o_sel != SEL_NONE);
    end
  end
`else
  assign o_blank = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed + randomized bench for time_set_ctrl against an integer hour/min/sec model.
module tb_time_set_ctrl;

  localparam int unsigned DEB_N  = 4;
  localparam int unsigned DEB_W  = 3;
  localparam int unsigned HOLD_N = 8;
  localparam int unsigned HOLD_W = 4;
  localparam int          SETTLE = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_mode, key_up, key_dn;
  logic [2:0] hq1, mq1, sq1;
  logic [3:0] hq0, mq0, sq0;
  logic       load;
  logic [2:0] hd1, md1, sd1;
  logic [3:0] hd0, md0, sd0;
  logic [1:0] sel;
  logic       blank;

  int errors = 0;
  int checks = 0;

  // Model: 0 idle, 1 hours, 2 minutes, 3 seconds (commit completes within a press)
  int m_state, m_h, m_m, m_s;

  time_set_ctrl #(.DEB_N(DEB_N), .DEB_W(DEB_W), .HOLD_N(HOLD_N), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_key_mode(key_mode), .i_key_up(key_up), .i_key_dn(key_dn),
    .i_hq1(hq1), .i_hq0(hq0), .i_mq1(mq1), .i_mq0(mq0), .i_sq1(sq1), .i_sq0(sq0),
    .o_load(load), .o_hd1(hd1), .o_hd0(hd0), .o_md1(md1), .o_md0(md0),
    .o_sd1(sd1), .o_sd0(sd0), .o_sel(sel), .o_blank(blank));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_load"}, 32'(load), (m_state != 0) ? 32'd1 : 32'd0);
    chk({tag, "_sel"}, 32'(sel), 32'(m_state));
    chk({tag, "_hour"}, 32'(hd1) * 10 + 32'(hd0), 32'(m_h));
    chk({tag, "_min"}, 32'(md1) * 10 + 32'(md0), 32'(m_m));
    chk({tag, "_sec"}, 32'(sd1) * 10 + 32'(sd0), 32'(m_s));
    chk({tag, "_blank"}, 32'(blank), 32'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input int h1, input int h0, input int m1, input int m0,
                          input int s1, input int s0);
    hq1 = 3'(h1); hq0 = 4'(h0); mq1 = 3'(m1); mq0 = 4'(m0); sq1 = 3'(s1); sq0 = 4'(s0);
  endtask

  function automatic int field_seed(input int tens, input int ones, input int max_val);
    int v;
    v = tens * 10 + ones;
    return (ones <= 9 && v <= max_val) ? v : 0;
  endfunction

  task automatic model_apply(input bit m, input bit u, input bit d);
    int step;
    step = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
    if (m) begin
      if (m_state == 0) begin
        m_h = field_seed(int'(hq1), int'(hq0), 23);
        m_m = field_seed(int'(mq1), int'(mq0), 59);
        m_s = field_seed(int'(sq1), int'(sq0), 59);
        m_state = 1;
      end else begin
        m_state = (m_state + 1) % 4;
      end
    end else begin
      case (m_state)
        1: m_h = (m_h + step + 24) % 24;
        2: m_m = (m_m + step + 60) % 60;
        3: m_s = (m_s + step + 60) % 60;
        default: ;
      endcase
    end
  endtask

  // Clean press and release of any key combination, then update the model
  task automatic press(input bit m, input bit u, input bit d);
    @(negedge clk);
    key_mode = ~m; key_up = ~u; key_dn = ~d;
    tick(SETTLE);
    key_mode = 1'b1; key_up = 1'b1; key_dn = 1'b1;
    tick(SETTLE);
    model_apply(m, u, d);
  endtask

  initial begin
    int w, n, r;
    rst_n = 1'b0;
    key_mode = 1'b1; key_up = 1'b1; key_dn = 1'b1;
    set_time(1, 2, 3, 4, 5, 6);
    m_state = 0; m_h = 0; m_m = 0; m_s = 0;
    tick(3);
    check_all("reset");
    rst_n = 1'b1;
    tick(2);

    press(0, 1, 0);
    check_all("idle_up_ignored");

    press(1, 0, 0);
    check_all("enter_12_34_56");
    for (int i = 0; i < 3; i++) begin
      press(0, 1, 0);
      check_all("hour_up");
    end
    chk("hour_is_15", 32'(hd1) * 10 + 32'(hd0), 32'd15);
    for (int i = 0; i < 9; i++) begin
      press(0, 1, 0);
      check_all("hour_up_wrap_path");
    end
    chk("hour_wrap_00", 32'(hd1) * 10 + 32'(hd0), 32'd0);

    press(1, 0, 0);
    check_all("to_set_m");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_state = 0; m_h = 0; m_m = 0; m_s = 0;
    check_all("reset_mid_edit");
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Bouncing mode key: only the final settled press counts
    set_time(0, 7, 5, 9, 1, 0);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      key_mode = (k % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    key_mode = 1'b0;
    tick(SETTLE);
    key_mode = 1'b1;
    tick(SETTLE);
    model_apply(1, 0, 0);
    check_all("bounce_one_step");

    press(0, 1, 1);
    check_all("up_dn_cancel");
    press(1, 1, 0);
    check_all("mode_beats_up");

    press(0, 1, 0);
    check_all("min_59_up");
    press(0, 0, 1);
    check_all("min_00_dn");
    press(1, 0, 0);
    check_all("to_set_s");
    press(0, 0, 1);
    check_all("sec_10_dn");
    press(1, 0, 0);
    check_all("commit_to_idle");

    // Randomized key sequences against the model
    for (int it = 0; it < 60; it++) begin
      set_time(int'($urandom_range(0, 7)), int'($urandom_range(0, 9)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 9)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 9)));
      r = int'($urandom_range(0, 9));
      if (r < 4)       press(0, 1, 0);
      else if (r < 8)  press(0, 0, 1);
      else if (r == 8) press(1, 0, 0);
      else             press(0, 1, 1);
      check_all("rnd");
    end

    // Return to idle, then a full pass with out-of-range live time
    while (m_state != 0) press(1, 0, 0);
    set_time(2, 7, 7, 5, 7, 0);
    press(1, 0, 0);
    check_all("clamp_capture");
    press(1, 0, 0);
    press(1, 0, 0);
    check_all("clamp_set_s");

    @(negedge clk);
    key_mode = 1'b0;
    w = 0;
    while (sel !== 2'd0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("commit_enter_in_time", (w < 40) ? 32'd1 : 32'd0, 32'd1);
    n = 0;
    while (load === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("commit_hold_len", 32'(n), 32'(HOLD_N));
    key_mode = 1'b1;
    tick(SETTLE);
    m_state = 0;
    check_all("after_commit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
